// File: rtl/snn_param_loader.sv
// rtl/snn_param_loader.sv - framed byte-stream loader for the SNN parameter array
// Shadow/active double buffer so the network only ever sees fully validated frames.
module snn_param_loader #(
  parameter int         NUM_PARAMS = 32,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] parameters [0:NUM_PARAMS-1],
  output logic       param_update,
  output logic       frame_error,
  output logic       busy
);
  localparam int            AW          = $clog2(NUM_PARAMS);
  localparam int            TW          = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    LIMIT       = 9'(NUM_PARAMS);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ADDR, COUNT, PAYLOAD, CHECK, SKIP, COMMIT, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [8:0]    remaining_q, remaining_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          s_ready_q, s_ready_d;
  logic          param_update_q, param_update_d;
  logic          frame_error_q, frame_error_d;
  logic          busy_q, busy_d;
  logic [7:0]    active_q [0:NUM_PARAMS-1];
  logic [7:0]    active_d [0:NUM_PARAMS-1];
  logic [7:0]    shadow_q [0:NUM_PARAMS-1];
  logic [7:0]    shadow_d [0:NUM_PARAMS-1];

  logic          xfer;
  logic [AW-1:0] wr_idx;
  logic [8:0]    end_addr;

  assign xfer     = s_valid && s_ready_q;
  assign wr_idx   = addr_q[AW-1:0] + idx_q[AW-1:0];
  // 9-bit sum so that an ADDR near 255 cannot wrap back into range
  assign end_addr = {1'b0, addr_q} + {1'b0, s_data};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    remaining_d = remaining_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    timer_d     = '0;
    if (state_q inside {ADDR, COUNT, PAYLOAD, CHECK, SKIP}) begin
      timer_d = xfer ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (xfer && s_data == SYNC_BYTE) state_d = ADDR;
      end
      ADDR: begin
        if (xfer) begin
          addr_d  = s_data;
          chk_d   = s_data;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (xfer) begin
          count_d = s_data;
          chk_d   = chk_q ^ s_data;
          idx_d   = '0;
          if (s_data == 8'd0 || end_addr > LIMIT) begin
            remaining_d = {1'b0, s_data} + 9'd1;
            state_d     = SKIP;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          shadow_d[wr_idx] = s_data;
          chk_d            = chk_q ^ s_data;
          idx_d            = idx_q + 8'd1;
          if (idx_q == count_q - 8'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) state_d = (s_data == chk_q) ? COMMIT : ERROR;
      end
      SKIP: begin
        if (xfer) begin
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) state_d = ERROR;
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      ERROR: begin
        shadow_d = active_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timer_d == TIMER_LIMIT) state_d = ERROR;

    s_ready_d      = !(state_d == COMMIT || state_d == ERROR);
    param_update_d = (state_q == COMMIT);
    frame_error_d  = (state_q == ERROR);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      chk_q          <= '0;
      remaining_q    <= '0;
      timer_q        <= '0;
      s_ready_q      <= 1'b1;
      param_update_q <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      chk_q          <= chk_d;
      remaining_q    <= remaining_d;
      timer_q        <= timer_d;
      s_ready_q      <= s_ready_d;
      param_update_q <= param_update_d;
      frame_error_q  <= frame_error_d;
      busy_q         <= busy_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign parameters   = active_q;
  assign param_update = param_update_q;
  assign frame_error  = frame_error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_snn_param_loader.sv
// tb/tb_snn_param_loader.sv - self-checking bench for snn_param_loader
// Reference model parses whole frames with plain arithmetic and tracks the committed array.
module tb_snn_param_loader;
  localparam int NP = 32;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] parameters [0:NP-1];
  logic       param_update;
  logic       frame_error;
  logic       busy;

  snn_param_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .parameters(parameters), .param_update(param_update), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pu_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int first_wait = 0;
  logic [7:0] exp_p [0:NP-1];

  always @(posedge clk) begin
    if (param_update === 1'b1) pu_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (param_update === 1'b1 && frame_error === 1'b1) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit model_frame(input logic [7:0] f[$]);
    int a;
    int c;
    logic [7:0] x;
    a = int'(f[1]);
    c = int'(f[2]);
    if (c == 0 || a + c > NP) return 1'b0;
    x = f[1] ^ f[2];
    for (int k = 0; k < c; k++) x ^= f[3 + k];
    if (x != f[3 + c]) return 1'b0;
    for (int k = 0; k < c; k++) exp_p[a + k] = f[3 + k];
    return 1'b1;
  endfunction

  task automatic make_frame(input int a, input int c, input bit corrupt, output logic [7:0] f[$]);
    logic [7:0] x;
    logic [7:0] b;
    f = {};
    f.push_back(8'hA5);
    f.push_back(8'(a));
    f.push_back(8'(c));
    x = 8'(a) ^ 8'(c);
    for (int k = 0; k < c; k++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    if (corrupt) x ^= 8'(1 << $urandom_range(7, 0));
    f.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    waits   = 0;
    while (s_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    @(negedge clk);
    waits++;
    s_valid = 1'b0;
    total++;
    if (waits > 20) begin
      bad++;
      $display("FAIL handshake_bound: waited %0d edges, limit 20", waits);
    end
  endtask

  task automatic run_frame(input logic [7:0] f[$], input int gap, input string name);
    logic [7:0] old_p [0:NP-1];
    bit ok;
    int w;
    int pu0;
    int fe0;
    int nd;
    old_p = exp_p;
    ok = model_frame(f);
    pu0 = 0;
    fe0 = 0;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (i == 0) ? 0 : int'($urandom_range(gap, 0)), w);
      if (i == 0) begin
        first_wait = w;
        pu0 = pu_cnt;
        fe0 = fe_cnt;
      end
    end
    nd = 0;
    for (int i = 0; i < NP; i++) if (parameters[i] !== old_p[i]) nd++;
    total++;
    if (param_update !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL %s early_pulse: got pu=%b fe=%b want 0 0", name, param_update, frame_error);
    end
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_in_final_state: got %b want 0", name, s_ready);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_in_final_state: got %b want 1", name, busy);
    end
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL %s params_before_commit: %0d entries changed, want 0", name, nd);
    end
    @(negedge clk);
    total++;
    if (param_update !== ok) begin
      bad++;
      $display("FAIL %s param_update: got %b want %b", name, param_update, ok);
    end
    total++;
    if (frame_error !== !ok) begin
      bad++;
      $display("FAIL %s frame_error: got %b want %b", name, frame_error, !ok);
    end
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s back_to_idle: got ready=%b busy=%b want 1 0", name, s_ready, busy);
    end
    nd = 0;
    for (int i = 0; i < NP; i++) begin
      if (parameters[i] !== exp_p[i]) begin
        if (nd == 0) $display("FAIL %s params[%0d]: got %h want %h", name, i, parameters[i], exp_p[i]);
        nd++;
      end
    end
    total++;
    if (nd != 0) bad++;
    @(negedge clk);
    total++;
    if (param_update !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse_width: got pu=%b fe=%b want 0 0", name, param_update, frame_error);
    end
    total++;
    if (pu_cnt - pu0 != int'(ok) || fe_cnt - fe0 != int'(!ok)) begin
      bad++;
      $display("FAIL %s pulse_count: got pu=%0d fe=%0d want %0d %0d", name,
               pu_cnt - pu0, fe_cnt - fe0, int'(ok), int'(!ok));
    end
    total++;
    if (both_cnt != 0) begin
      bad++;
      $display("FAIL %s pulse_overlap: got %0d cycles want 0", name, both_cnt);
    end
  endtask

  task automatic test_reset;
    int nd;
    rst = 1'b0;
    s_data = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      s_valid = ~s_valid;
      @(negedge clk);
      nd = 0;
      for (int i = 0; i < NP; i++) if (parameters[i] !== 8'h00) nd++;
      total++;
      if (nd != 0 || s_ready !== 1'b1 || busy !== 1'b0 || param_update !== 1'b0 || frame_error !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: nonzero=%0d ready=%b busy=%b pu=%b fe=%b want 0 1 0 0 0",
                 nd, s_ready, busy, param_update, frame_error);
      end
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pu_cnt != 0 || fe_cnt != 0) begin
      bad++;
      $display("FAIL reset_pulses: got pu=%0d fe=%0d want 0 0", pu_cnt, fe_cnt);
    end
  endtask

  task automatic test_good_frame;
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
    run_frame(f, 0, "good");
    run_frame(f, 6, "good_gaps");
  endtask

  task automatic test_bad_checksum;
    logic [7:0] f[$];
    f = '{8'hA5, 8'h04, 8'h02, 8'hAA, 8'hBB, 8'h00};
    run_frame(f, 3, "bad_chk");
    f = '{8'hA5, 8'h04, 8'h01, 8'h55, 8'h50};
    run_frame(f, 3, "after_bad_chk");
  endtask

  task automatic test_range_error;
    logic [7:0] f[$];
    f = '{8'hA5, 8'h1E, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'h99};
    run_frame(f, 2, "range");
    make_frame(8, 4, 1'b0, f);
    run_frame(f, 2, "after_range");
  endtask

  task automatic test_boundary;
    logic [7:0] f[$];
    f = '{8'hA5, 8'h1F, 8'h01, 8'h7F, 8'h60};
    run_frame(f, 1, "last_entry_wrong_chk");
    f = '{8'hA5, 8'h1F, 8'h01, 8'h7F, 8'h61};
    run_frame(f, 1, "last_entry");
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(f, 1, "count_zero");
    make_frame(0, 32, 1'b0, f);
    run_frame(f, 1, "full_array");
    make_frame(1, 32, 1'b0, f);
    run_frame(f, 1, "one_past_end");
  endtask

  task automatic test_back_to_back;
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    int w;
    int pu0;
    bit ok1;
    make_frame(2, 3, 1'b0, f1);
    make_frame(10, 2, 1'b0, f2);
    pu0 = pu_cnt;
    ok1 = model_frame(f1);
    foreach (f1[i]) send_byte(f1[i], 0, w);
    run_frame(f2, 0, "b2b");
    total++;
    if (first_wait != 2) begin
      bad++;
      $display("FAIL b2b_sync_latency: got %0d edges want 2", first_wait);
    end
    total++;
    if (pu_cnt - pu0 != int'(ok1) + 1) begin
      bad++;
      $display("FAIL b2b_commits: got %0d want %0d", pu_cnt - pu0, int'(ok1) + 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] f[$];
    logic [7:0] junk;
    int w;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(2, 0) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, int'($urandom_range(3, 0)), w);
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL junk_in_idle: busy got %b want 0", busy);
        end
      end
      make_frame(int'($urandom_range(35, 0)), int'($urandom_range(8, 0)),
                 $urandom_range(3, 0) == 0, f);
      run_frame(f, 5, "random");
    end
  endtask

  task automatic test_timeout;
    int w;
    int k;
    int nd;
    logic rdy_at;
    rdy_at = 1'b1;
    send_byte(8'hA5, 0, w);
    send_byte(8'h05, 0, w);
    k = 0;
    while (frame_error !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      if (k == TO) rdy_at = s_ready;
    end
    total++;
    if (k != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency: frame_error after %0d edges want %0d", k, TO + 1);
    end
    total++;
    if (rdy_at !== 1'b0) begin
      bad++;
      $display("FAIL timeout_error_ready: got %b want 0", rdy_at);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_busy: got %b want 0", busy);
    end
    nd = 0;
    for (int i = 0; i < NP; i++) if (parameters[i] !== exp_p[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL timeout_params: %0d entries differ, want 0", nd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] f[$];
    int w;
    int pu0;
    int nd;
    f = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22};
    foreach (f[i]) send_byte(f[i], 0, w);
    pu0 = pu_cnt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NP; i++) exp_p[i] = 8'h00;
    nd = 0;
    for (int i = 0; i < NP; i++) if (parameters[i] !== 8'h00) nd++;
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL reset_mid_params: %0d entries nonzero, want 0", nd);
    end
    total++;
    if (pu_cnt != pu0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_state: pu_delta=%0d busy=%b ready=%b want 0 0 1",
               pu_cnt - pu0, busy, s_ready);
    end
    make_frame(20, 5, 1'b0, f);
    run_frame(f, 2, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < NP; i++) exp_p[i] = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_range_error();
    test_boundary();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
